// File: rtl/line_memory_pkg.sv
// Shared widths and the FSM state type for the line_memory backing store.
package line_memory_pkg;

  localparam int LINE_W      = 128;
  localparam int OFFSET_BITS = 4;
  localparam int COUNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } lm_state_t;

endpackage

// File: rtl/line_memory_ram.sv
// Line array for line_memory: one synchronous write port and one registered read port.
module line_ram
  import line_memory_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [DEPTH_LINES];
  logic [LINE_W-1:0] rdata_q;

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Fixed-latency 128-bit line store with read, write and combined write-back-then-fill.
// Optional rd_total/wr_total counters are built when LINE_MEMORY_PERF_EN is defined.
module line_memory
  import line_memory_pkg::*;
#(
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic [31:0]        read_address,
  input  logic               write,
  input  logic [31:0]        write_address,
  input  logic [LINE_W-1:0]  write_data,
  output logic [LINE_W-1:0]  read_data,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
`ifdef LINE_MEMORY_PERF_EN
  ,
  output logic [31:0]        rd_total,
  output logic [31:0]        wr_total
`endif
);

  localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [COUNT_W-1:0] LAT_C = COUNT_W'(LATENCY);

  lm_state_t          state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               done_q, done_d;
  logic               rdFlag_q, rdFlag_d;
  logic [IDX_W-1:0]   wrIdx_q, wrIdx_d;
  logic [IDX_W-1:0]   rdIdx_q, rdIdx_d;
  logic [LINE_W-1:0]  wrData_q, wrData_d;
  logic               ramWe, ramRe;

  // Upper address bits alias and the byte offset is irrelevant to a line access.
  logic unused_addrBits;
  assign unused_addrBits = ^{read_address[31:OFFSET_BITS+IDX_W], read_address[OFFSET_BITS-1:0],
                             write_address[31:OFFSET_BITS+IDX_W], write_address[OFFSET_BITS-1:0]};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
    rdFlag_d = rdFlag_q;
    wrIdx_d  = wrIdx_q;
    rdIdx_d  = rdIdx_q;
    wrData_d = wrData_q;
    ramWe    = 1'b0;
    ramRe    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (write) begin
          wrIdx_d  = write_address[OFFSET_BITS +: IDX_W];
          rdIdx_d  = read_address[OFFSET_BITS +: IDX_W];
          wrData_d = write_data;
          rdFlag_d = read;
          count_d  = COUNT_W'(1);
          state_d  = WR;
        end else if (read) begin
          rdIdx_d  = read_address[OFFSET_BITS +: IDX_W];
          rdFlag_d = 1'b0;
          count_d  = COUNT_W'(1);
          state_d  = RD;
        end
      end
      WR: begin
        if (count_q == LAT_C) begin
          ramWe = 1'b1;
          // A pending fill restarts the counter without signalling completion.
          if (rdFlag_q) begin
            count_d = COUNT_W'(1);
            state_d = RD;
          end else begin
            count_d = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      RD: begin
        if (count_q == LAT_C) begin
          ramRe   = 1'b1;
          count_d = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          count_d = count_q + COUNT_W'(1);
        end
      end
      default: begin
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      done_q   <= 1'b0;
      rdFlag_q <= 1'b0;
      wrIdx_q  <= '0;
      rdIdx_q  <= '0;
      wrData_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      done_q   <= done_d;
      rdFlag_q <= rdFlag_d;
      wrIdx_q  <= wrIdx_d;
      rdIdx_q  <= rdIdx_d;
      wrData_q <= wrData_d;
    end
  end

  // Gating with reset keeps an aborted write-back out of the array.
  line_ram #(
    .DEPTH_LINES(DEPTH_LINES),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ramWe & ~reset),
    .waddr(wrIdx_q),
    .wdata(wrData_q),
    .re   (ramRe & ~reset),
    .raddr(rdIdx_q),
    .rdata(read_data)
  );

  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;

`ifdef LINE_MEMORY_PERF_EN
  logic [31:0] rdTotal_q, wrTotal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rdTotal_q <= '0;
      wrTotal_q <= '0;
    end else begin
      if (ramRe) rdTotal_q <= rdTotal_q + 32'd1;
      if (ramWe) wrTotal_q <= wrTotal_q + 32'd1;
    end
  end

  assign rd_total = rdTotal_q;
  assign wr_total = wrTotal_q;
`endif

endmodule

// File: doc/line_memory.md
# line_memory

Backing line store directly downstream of the data cache; services one 128-bit line fill (read) or line write-back (write) at a time with a fixed, programmable access latency. Exposes a running access counter (`count`) that the cache polls to pace its miss handling, plus explicit `busy`/`done` handshake outputs. A combined write-back-then-fill request is supported so a dirty eviction and its refill issue in one transaction.

## Interface
Parameters:
- `DEPTH_LINES`, 256: number of 128-bit lines; power of two, 2..65536.
- `LATENCY`, 4: cycles per array access; 1..31.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `read` in 1: line-fill request; sampled only when idle.
- `read_address` in 32: byte address of line to read.
- `write` in 1: line write-back request; sampled only when idle.
- `write_address` in 32: byte address of line to write.
- `write_data` in 128: line to write.
- `read_data` out 128: registered fill data; holds until the next read completes.
- `count` out 5: cycles elapsed in the current access phase; 0 when idle.
- `busy` out 1: transaction in progress; new requests ignored.
- `done` out 1: one-cycle pulse marking transaction completion.
- `rd_total`, `wr_total` out 32 each: only with `LINE_MEMORY_PERF_EN`.

## Operation
- Line index = `addr[4 +: log2(DEPTH_LINES)]`; bits [3:0] ignored; upper bits ignored, so addresses alias modulo `DEPTH_LINES*16`.
- FSM states: IDLE, WR, RD.
- IDLE: if `write`, latch both addresses, `write_data` and the `read` flag, then go to WR. Else if `read`, latch `read_address` and go to RD. Else stay.
- WR: when `count==LATENCY`, write the latched line into the array. If the read flag was latched, go to RD with `count` restarted at 1 and `done` withheld. Otherwise go to IDLE and pulse `done`.
- RD: when `count==LATENCY`, load `read_data` from the array, pulse `done`, and go to IDLE.
- A combined request whose two addresses map to the same line returns the newly written data.
- Requests arriving while `busy=1` are dropped, not queued. The requester must hold or re-issue them.
- Array contents are not cleared by reset.

## Timing
- Reset values: `busy=0`, `done=0`, `count=0`, `read_data=0`, state IDLE. Perf counters reset to 0.
- Request accepted at edge E0:
  - `busy=1` and `count=1` after E0.
  - `count` increments on each following edge.
  - At edge E(LATENCY), `done=1`, `busy=0`, `count=0`, and `read_data` is valid in the same cycle.
- Single read or write: `done` appears LATENCY cycles after acceptance.
- Combined request: `done` appears 2*LATENCY cycles after acceptance. There is exactly one `done` pulse and `busy` stays high throughout.
- The `done` cycle is IDLE, so a new request is accepted on that cycle, giving back-to-back throughput.
- Reset mid-transaction aborts it: no array write, no `done`, `read_data` cleared.

## Configuration
- `LINE_MEMORY_PERF_EN` defined:
  - `rd_total` increments once per completed RD phase; `wr_total` once per completed WR phase.
  - Both wrap at 2^32.
- Not defined: the `rd_total`/`wr_total` ports and their counters are absent.

## Structure
- Package `line_memory_pkg`:
  - `LINE_W=128`, `OFFSET_BITS=4`, `COUNT_W=5`.
  - State enum `lm_state_t` {IDLE, WR, RD}.
- Sub-module `line_ram`: `DEPTH_LINES`×128 array with one synchronous write port and one registered read port, enabled by the FSM.
- The FSM, latch registers and counter live in the top module.

## Test plan
- Reset held 2 cycles → `busy=0`, `done=0`, `count=0`, `read_data=0`.
- Write 0x0000 data 128'h9, LATENCY=4 → `count` 1,2,3,4 then `done` on the 4th cycle after accept. Read 0x0000 → `read_data=128'h9` with `done` 4 cycles later.
- Combined write 0x0010 data 128'hA5 plus read 0x0010 → single `done` 8 cycles after accept, `read_data=128'hA5`.
- Alias, DEPTH_LINES=256: write 0x1000 data 128'h77, then read 0x0000 → `read_data=128'h77`. Read 0x0004 → also 128'h77.
- Dropped request and reset:
  - `read` pulsed while `busy` → ignored, no extra `done`.
  - `reset` at `count=2` of a write to 0x0020 (prior content 128'h1) → a later read returns 128'h1.
- With `LINE_MEMORY_PERF_EN`: 3 writes, 2 reads and 1 combined → `wr_total=4`, `rd_total=3`.
